// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative write-back, write-allocate data cache.
// Ports: clock/reset (sync, active-high); req_* request, resp_* response;
//   flush_req/flush_done cache flush; proc2Dmem_* / Dmem2proc_* block bus.
module dcache_assoc #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [63:0]     resp_data,
  input  logic            flush_req,
  output logic            flush_done,
  output logic [1:0]      proc2Dmem_command,
  output logic [XLEN-1:0] proc2Dmem_addr,
  output logic [63:0]     proc2Dmem_data,
  input  logic [3:0]      Dmem2proc_response,
  input  logic [63:0]     Dmem2proc_data,
  input  logic [3:0]      Dmem2proc_tag
);

  localparam int IDXW = $clog2(NUM_SETS);
  localparam int WAYW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAGW = XLEN - 3 - IDXW;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;

  localparam logic [WAYW-1:0] LAST_WAY = WAYW'(NUM_WAYS - 1);
  localparam logic [IDXW-1:0] LAST_SET = IDXW'(NUM_SETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_FL_SCAN,
    S_FL_WB
  } state_t;

  typedef logic [NUM_WAYS-1:0][WAYW-1:0] age_row_t;

  logic [NUM_WAYS-1:0] valid [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty [NUM_SETS];
  logic [TAGW-1:0]     tags  [NUM_SETS][NUM_WAYS];
  logic [63:0]         data  [NUM_SETS][NUM_WAYS];
  age_row_t            age   [NUM_SETS];

  state_t          state;
  logic [IDXW-1:0] m_idx;
  logic [TAGW-1:0] m_tag;
  logic            m_wr;
  logic [1:0]      m_size;
  logic [2:0]      m_off;
  logic [XLEN-1:0] m_wdata;
  logic [WAYW-1:0] m_way;
  logic [3:0]      m_mtag;
  logic [IDXW-1:0] fl_set;
  logic [WAYW-1:0] fl_way;

  logic [IDXW-1:0] r_idx;
  logic [TAGW-1:0] r_tag;
  logic            hit;
  logic [WAYW-1:0] hit_way;
  logic [WAYW-1:0] vic;
  logic            vic_found;
  logic [63:0]     hit_blk;
  logic [63:0]     hit_new;
  logic [63:0]     fill_new;
  logic            fl_last;
  logic            tag_match;

  // Replace the store lane inside a 64-bit block.
  function automatic logic [63:0] merge(
    input logic [63:0]     blk,
    input logic [2:0]      off,
    input logic [1:0]      sz,
    input logic [XLEN-1:0] wd
  );
    logic [63:0] r;
    r = blk;
    unique case (1'b1)
      (sz == MEM_BYTE): r[{off, 3'b000} +: 8] = wd[7:0];
      (sz == MEM_HALF): r[{off[2:1], 4'b0000} +: 16] = wd[15:0];
      default:          r[{off[2], 5'b00000} +: 32] = wd[31:0];
    endcase
    return r;
  endfunction

  // Touched way becomes youngest; younger ways than it age by one.
  function automatic age_row_t touch(
    input age_row_t        row,
    input logic [WAYW-1:0] w
  );
    age_row_t r;
    r = row;
    for (int j = 0; j < NUM_WAYS; j++) begin
      if (WAYW'(j) == w) r[j] = '0;
      else if (row[j] < row[w]) r[j] = row[j] + 1'b1;
    end
    return r;
  endfunction

  assign r_idx = req_addr[3 +: IDXW];
  assign r_tag = req_addr[XLEN-1 -: TAGW];
  assign req_ready = (state == S_IDLE);

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int j = 0; j < NUM_WAYS; j++) begin
      if (valid[r_idx][j] && tags[r_idx][j] == r_tag) begin
        hit = 1'b1;
        hit_way = WAYW'(j);
      end
    end
  end

  // Lowest invalid way first, otherwise the oldest way.
  always_comb begin
    vic = '0;
    vic_found = 1'b0;
    for (int j = 0; j < NUM_WAYS; j++) begin
      if (!vic_found && !valid[r_idx][j]) begin
        vic = WAYW'(j);
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int j = 0; j < NUM_WAYS; j++) begin
        if (age[r_idx][j] == LAST_WAY) vic = WAYW'(j);
      end
    end
  end

  assign hit_blk = data[r_idx][hit_way];
  assign hit_new = merge(hit_blk, req_addr[2:0], req_size, req_wdata);
  assign fill_new = m_wr ?
    merge(Dmem2proc_data, m_off, m_size, m_wdata) : Dmem2proc_data;
  assign fl_last = (fl_set == LAST_SET) && (fl_way == LAST_WAY);
  assign tag_match = (Dmem2proc_tag != 4'd0) && (Dmem2proc_tag == m_mtag);

  always_comb begin
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr = '0;
    proc2Dmem_data = '0;
    case (state)
      S_WB: begin
        proc2Dmem_command = BUS_STORE;
        proc2Dmem_addr = {tags[m_idx][m_way], m_idx, 3'b000};
        proc2Dmem_data = data[m_idx][m_way];
      end
      S_FILL_REQ: begin
        proc2Dmem_command = BUS_LOAD;
        proc2Dmem_addr = {m_tag, m_idx, 3'b000};
      end
      S_FL_WB: begin
        proc2Dmem_command = BUS_STORE;
        proc2Dmem_addr = {tags[fl_set][fl_way], fl_set, 3'b000};
        proc2Dmem_data = data[fl_set][fl_way];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      resp_valid <= 1'b0;
      resp_data <= '0;
      flush_done <= 1'b0;
      m_idx <= '0;
      m_tag <= '0;
      m_wr <= 1'b0;
      m_size <= '0;
      m_off <= '0;
      m_wdata <= '0;
      m_way <= '0;
      m_mtag <= '0;
      fl_set <= '0;
      fl_way <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age[s][w] <= WAYW'(w);
      end
    end else begin
      resp_valid <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush_req) begin
            state <= S_FL_SCAN;
            fl_set <= '0;
            fl_way <= '0;
          end else if (req_valid) begin
            if (hit) begin
              resp_valid <= 1'b1;
              age[r_idx] <= touch(age[r_idx], hit_way);
              if (req_wr) begin
                data[r_idx][hit_way] <= hit_new;
                dirty[r_idx][hit_way] <= 1'b1;
                resp_data <= hit_new;
              end else begin
                resp_data <= hit_blk;
              end
            end else begin
              m_idx <= r_idx;
              m_tag <= r_tag;
              m_wr <= req_wr;
              m_size <= req_size;
              m_off <= req_addr[2:0];
              m_wdata <= req_wdata;
              m_way <= vic;
              if (valid[r_idx][vic] && dirty[r_idx][vic]) state <= S_WB;
              else state <= S_FILL_REQ;
            end
          end
        end
        S_WB: begin
          if (Dmem2proc_response != 4'd0) begin
            dirty[m_idx][m_way] <= 1'b0;
            state <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: begin
          if (Dmem2proc_response != 4'd0) begin
            m_mtag <= Dmem2proc_response;
            state <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          if (tag_match) begin
            valid[m_idx][m_way] <= 1'b1;
            dirty[m_idx][m_way] <= m_wr;
            tags[m_idx][m_way] <= m_tag;
            data[m_idx][m_way] <= fill_new;
            age[m_idx] <= touch(age[m_idx], m_way);
            resp_valid <= 1'b1;
            resp_data <= fill_new;
            state <= S_IDLE;
          end
        end
        S_FL_SCAN, S_FL_WB: begin
          if (state == S_FL_SCAN && valid[fl_set][fl_way]
              && dirty[fl_set][fl_way]) begin
            state <= S_FL_WB;
          end else if (state == S_FL_SCAN
                       || Dmem2proc_response != 4'd0) begin
            valid[fl_set][fl_way] <= 1'b0;
            dirty[fl_set][fl_way] <= 1'b0;
            if (fl_last) begin
              flush_done <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_FL_SCAN;
              if (fl_way == LAST_WAY) begin
                fl_way <= '0;
                fl_set <= fl_set + 1'b1;
              end else begin
                fl_way <= fl_way + 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed bench for dcache_assoc (16 sets, 2 ways)
// with a behavioural block memory answering on the falling edge.
module tb_dcache_assoc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [3:0]  Dmem2proc_response = '0;
  logic [63:0] Dmem2proc_data = '0;
  logic [3:0]  Dmem2proc_tag = '0;

  int tests = 0;
  int fails = 0;

  dcache_assoc #(.NUM_SETS(16), .NUM_WAYS(2), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .proc2Dmem_command(proc2Dmem_command),
    .proc2Dmem_addr(proc2Dmem_addr),
    .proc2Dmem_data(proc2Dmem_data),
    .Dmem2proc_response(Dmem2proc_response),
    .Dmem2proc_data(Dmem2proc_data),
    .Dmem2proc_tag(Dmem2proc_tag)
  );

  always #5 clock = ~clock;

  logic [63:0] mem [logic [31:0]];
  logic [1:0]  log_cmd [$];
  logic [31:0] log_addr [$];
  logic [63:0] log_data [$];
  int          rej_left = 0;
  int          rej_seen = 0;
  int          unstable = 0;
  int          ret_cnt = 0;
  logic [3:0]  pend_tag = '0;
  logic [63:0] pend_data = '0;
  logic [3:0]  next_tag = 4'd1;
  logic        prev_rej = 1'b0;
  logic [1:0]  prev_cmd = '0;
  logic [31:0] prev_addr = '0;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'h5A5A0000, a ^ 32'hFFFF0000};
  endfunction

  // Memory: accepts unless told to reject, returns loads 2 cycles later.
  always @(negedge clock) begin
    Dmem2proc_tag = 4'd0;
    if (ret_cnt > 0) begin
      ret_cnt--;
      if (ret_cnt == 0) begin
        Dmem2proc_tag = pend_tag;
        Dmem2proc_data = pend_data;
      end
    end
    Dmem2proc_response = 4'd0;
    if (prev_rej && (proc2Dmem_command != prev_cmd
        || proc2Dmem_addr != prev_addr)) unstable++;
    prev_rej = 1'b0;
    if (proc2Dmem_command != 2'd0) begin
      if (rej_left > 0) begin
        rej_left--;
        rej_seen++;
        prev_rej = 1'b1;
        prev_cmd = proc2Dmem_command;
        prev_addr = proc2Dmem_addr;
      end else begin
        Dmem2proc_response = next_tag;
        log_cmd.push_back(proc2Dmem_command);
        log_addr.push_back(proc2Dmem_addr);
        log_data.push_back(proc2Dmem_data);
        if (proc2Dmem_command == 2'd1) begin
          pend_tag = next_tag;
          pend_data = mem.exists(proc2Dmem_addr) ?
            mem[proc2Dmem_addr] : pat(proc2Dmem_addr);
          ret_cnt = 2;
        end else begin
          mem[proc2Dmem_addr] = proc2Dmem_data;
        end
        next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
      end
    end
  end

  task automatic clear_log();
    log_cmd.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic access(
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [1:0]  sz,
    input  logic [31:0] wd,
    output logic [63:0] d,
    output int          lat
  );
    int g;
    g = 0;
    @(negedge clock);
    while (!req_ready && g < 200) begin
      @(negedge clock);
      g++;
    end
    req_valid = 1'b1;
    req_wr = wr;
    req_addr = a;
    req_size = sz;
    req_wdata = wd;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    d = resp_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    tests++; if (resp_data !== 64'd0) begin fails++; $display("FAIL rst_resp_data got %h want 0", resp_data); end
    tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL rst_flush_done got %b want 0", flush_done); end
    tests++; if (proc2Dmem_command !== 2'd0) begin fails++; $display("FAIL rst_cmd got %0d want 0", proc2Dmem_command); end
    tests++; if (proc2Dmem_addr !== 32'd0) begin fails++; $display("FAIL rst_addr got %h want 0", proc2Dmem_addr); end
    tests++; if (proc2Dmem_data !== 64'd0) begin fails++; $display("FAIL rst_data got %h want 0", proc2Dmem_data); end
  endtask

  task automatic test_load_miss();
    logic [63:0] d;
    int lat;
    mem[32'h100] = 64'h1122334455667788;
    clear_log();
    access(1'b0, 32'h100, 2'd2, 32'd0, d, lat);
    tests++; if (d !== 64'h1122334455667788) begin fails++; $display("FAIL miss_data got %h want 1122334455667788", d); end
    tests++; if (lat !== 4) begin fails++; $display("FAIL miss_lat got %0d want 4", lat); end
    tests++; if (log_cmd.size() !== 1 || log_cmd[0] !== 2'd1 || log_addr[0] !== 32'h100) begin
      fails++; $display("FAIL miss_bus got n=%0d cmd=%0d addr=%h want 1 load 100", log_cmd.size(), log_cmd[0], log_addr[0]);
    end
    clear_log();
    access(1'b0, 32'h104, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL hit_lat got %0d want 1", lat); end
    tests++; if (d !== 64'h1122334455667788) begin fails++; $display("FAIL hit_data got %h want 1122334455667788", d); end
    tests++; if (log_cmd.size() !== 0) begin fails++; $display("FAIL hit_bus got %0d cmds want 0", log_cmd.size()); end
  endtask

  task automatic test_store_evict();
    logic [63:0] d;
    int lat;
    access(1'b1, 32'h104, 2'd2, 32'hDEADBEEF, d, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL st_hit_lat got %0d want 1", lat); end
    tests++; if (d !== 64'hDEADBEEF55667788) begin fails++; $display("FAIL st_hit_data got %h want deadbeef55667788", d); end
    access(1'b0, 32'h180, 2'd2, 32'd0, d, lat);
    tests++; if (d !== {32'h5A5A0180, 32'hFFFF0180}) begin fails++; $display("FAIL fill180_data got %h want 5a5a0180ffff0180", d); end
    clear_log();
    access(1'b0, 32'h200, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 5) begin fails++; $display("FAIL evict_lat got %0d want 5", lat); end
    tests++; if (log_cmd.size() !== 2) begin fails++; $display("FAIL evict_n got %0d want 2", log_cmd.size()); end
    tests++; if (log_cmd[0] !== 2'd2 || log_addr[0] !== 32'h100 || log_data[0] !== 64'hDEADBEEF55667788) begin
      fails++; $display("FAIL evict_wb got cmd=%0d addr=%h data=%h want 2 100 deadbeef55667788", log_cmd[0], log_addr[0], log_data[0]);
    end
    tests++; if (log_cmd[1] !== 2'd1 || log_addr[1] !== 32'h200) begin
      fails++; $display("FAIL evict_ld got cmd=%0d addr=%h want 1 200", log_cmd[1], log_addr[1]);
    end
    clear_log();
    access(1'b0, 32'h100, 2'd2, 32'd0, d, lat);
    tests++; if (d !== 64'hDEADBEEF55667788) begin fails++; $display("FAIL refetch_data got %h want deadbeef55667788", d); end
    tests++; if (log_cmd.size() !== 1 || log_cmd[0] !== 2'd1) begin
      fails++; $display("FAIL clean_evict got n=%0d cmd=%0d want 1 load", log_cmd.size(), log_cmd[0]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h100;
    @(negedge clock);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b1 || resp_data !== 64'hDEADBEEF55667788) begin
      fails++; $display("FAIL b2b_first got v=%b d=%h want 1 deadbeef55667788", resp_valid, resp_data);
    end
    req_addr = 32'h200;
    @(negedge clock);
    req_valid = 1'b0;
    tests++; if (resp_valid !== 1'b1 || resp_data !== {32'h5A5A0200, 32'hFFFF0200}) begin
      fails++; $display("FAIL b2b_second got v=%b d=%h want 1 5a5a0200ffff0200", resp_valid, resp_data);
    end
  endtask

  task automatic test_lru();
    logic [63:0] d;
    int lat;
    access(1'b0, 32'h008, 2'd2, 32'd0, d, lat);
    access(1'b0, 32'h088, 2'd2, 32'd0, d, lat);
    access(1'b0, 32'h008, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL lru_a_hit got %0d want 1", lat); end
    access(1'b0, 32'h108, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL lru_c_miss got %0d want 4", lat); end
    access(1'b0, 32'h008, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL lru_a_kept got %0d want 1", lat); end
    clear_log();
    access(1'b0, 32'h088, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 4 || log_addr.size() !== 1 || log_addr[0] !== 32'h088) begin
      fails++; $display("FAIL lru_b_evicted got lat=%0d n=%0d want 4 1", lat, log_addr.size());
    end
  endtask

  task automatic test_reject();
    logic [63:0] d;
    int lat;
    clear_log();
    rej_seen = 0;
    unstable = 0;
    rej_left = 2;
    access(1'b0, 32'h010, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 6) begin fails++; $display("FAIL rej_lat got %0d want 6", lat); end
    tests++; if (rej_seen !== 2) begin fails++; $display("FAIL rej_count got %0d want 2", rej_seen); end
    tests++; if (unstable !== 0) begin fails++; $display("FAIL rej_stable got %0d changes want 0", unstable); end
    tests++; if (d !== {32'h5A5A0010, 32'hFFFF0010}) begin fails++; $display("FAIL rej_data got %h want 5a5a0010ffff0010", d); end
  endtask

  task automatic test_flush();
    logic [63:0] d;
    int lat;
    int pulses;
    int after;
    logic rdy;
    access(1'b1, 32'h013, 2'd0, 32'h000000AB, d, lat);
    tests++; if (lat !== 1 || d !== {32'h5A5A0010, 32'hABFF0010}) begin
      fails++; $display("FAIL st_byte got lat=%0d d=%h want 1 5a5a0010abff0010", lat, d);
    end
    access(1'b1, 32'h08A, 2'd1, 32'h00001234, d, lat);
    tests++; if (lat !== 1 || d !== {32'h5A5A0088, 32'h12340088}) begin
      fails++; $display("FAIL st_half got lat=%0d d=%h want 1 5a5a008812340088", lat, d);
    end
    clear_log();
    @(negedge clock);
    flush_req = 1'b1;
    @(negedge clock);
    flush_req = 1'b0;
    pulses = 0;
    after = 0;
    rdy = 1'b0;
    for (int i = 0; i < 400 && after < 4; i++) begin
      @(negedge clock);
      if (flush_done) begin
        pulses++;
        if (pulses == 1) rdy = req_ready;
      end
      if (pulses > 0) after++;
    end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL fl_pulses got %0d want 1", pulses); end
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL fl_ready got %b want 1", rdy); end
    tests++; if (log_cmd.size() !== 2) begin fails++; $display("FAIL fl_n got %0d want 2", log_cmd.size()); end
    tests++; if (log_cmd[0] !== 2'd2 || log_addr[0] !== 32'h088 || log_data[0] !== {32'h5A5A0088, 32'h12340088}) begin
      fails++; $display("FAIL fl_wb0 got cmd=%0d addr=%h data=%h want 2 088", log_cmd[0], log_addr[0], log_data[0]);
    end
    tests++; if (log_cmd[1] !== 2'd2 || log_addr[1] !== 32'h010 || log_data[1] !== {32'h5A5A0010, 32'hABFF0010}) begin
      fails++; $display("FAIL fl_wb1 got cmd=%0d addr=%h data=%h want 2 010", log_cmd[1], log_addr[1], log_data[1]);
    end
    access(1'b0, 32'h010, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 4 || d !== {32'h5A5A0010, 32'hABFF0010}) begin
      fails++; $display("FAIL fl_inval010 got lat=%0d d=%h want 4 5a5a0010abff0010", lat, d);
    end
    access(1'b0, 32'h100, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL fl_inval100 got %0d want 4", lat); end
  endtask

  task automatic test_reset_mid_miss();
    logic [63:0] d;
    int lat;
    int stray;
    clear_log();
    @(negedge clock);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h300; req_size = 2'd2;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    tests++; if (log_cmd.size() !== 1 || req_ready !== 1'b0 || proc2Dmem_command !== 2'd0) begin
      fails++; $display("FAIL mid_fill_wait got n=%0d rdy=%b cmd=%0d want 1 0 0", log_cmd.size(), req_ready, proc2Dmem_command);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'd0 || proc2Dmem_command !== 2'd0) begin
      fails++; $display("FAIL mid_rst_outs got rdy=%b v=%b d=%h cmd=%0d want 1 0 0 0", req_ready, resp_valid, resp_data, proc2Dmem_command);
    end
    stray = 0;
    repeat (4) begin
      @(negedge clock);
      if (resp_valid) stray++;
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL mid_rst_stray got %0d pulses want 0", stray); end
    clear_log();
    access(1'b0, 32'h300, 2'd2, 32'd0, d, lat);
    tests++; if (lat !== 4 || log_cmd.size() !== 1 || d !== {32'h5A5A0300, 32'hFFFF0300}) begin
      fails++; $display("FAIL mid_rst_refill got lat=%0d n=%0d d=%h want 4 1 5a5a0300ffff0300", lat, log_cmd.size(), d);
    end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store_evict();
    test_back_to_back();
    test_lru();
    test_reject();
    test_flush();
    test_reset_mid_miss();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
